rectangle_rkey_cipher: RTL and testbench

- Consumer end of the round-key write interface driven by the RECTANGLE-128 key schedule (flush, WE, WAddr, KeyIn).
- Stores the 26 64-bit round keys in a local register file.
- Runs a 64-bit RECTANGLE block encryption, one round per cycle, with valid/ready handshakes on the plaintext input and the ciphertext output.
- Sits between the key-schedule generator and the top-level cipher wrapper.

---
 rtl/rectangle_pkg.sv | 56 +++++
 rtl/rectangle_rkey_cipher_if.sv | 32 +++
 rtl/rectangle_round.sv | 31 +++
 rtl/rectangle_rkey_cipher.sv | 157 +++++++++++++++
 tb/tb_rectangle_rkey_cipher.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rectangle_pkg.sv
// rectangle_pkg: shared definitions for the RECTANGLE-64/128 round-key consumer.
//   NUM_ROUNDS / NUM_RKEYS : round count and stored round-key count
//   rect_state_t           : 64-bit state/key word (4 rows x 16 bits, row j = bits[16j+15:16j])
//   SBOX / INV_SBOX        : forward and inverse 4-bit S-boxes
//   rect_fsm_e             : block FSM states
//   sub_column / shift_row / inv_shift_row : round building blocks
package rectangle_pkg;

  localparam int NUM_ROUNDS = 25;
  localparam int NUM_RKEYS  = NUM_ROUNDS + 1;

  typedef logic [63:0] rect_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rect_fsm_e;

  localparam logic [3:0] SBOX [16] = '{
    4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
    4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h9, 4'h4, 4'hF, 4'hA, 4'hE, 4'h1, 4'h0, 4'h6,
    4'hC, 4'h7, 4'h3, 4'h8, 4'h2, 4'hB, 4'h5, 4'hD
  };

  // Column i is the nibble {row3[i], row2[i], row1[i], row0[i]}; row0 is the LSB.
  function automatic rect_state_t sub_column(rect_state_t s, logic inv);
    rect_state_t o;
    logic [3:0]  nib;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      nib = {s[48+i], s[32+i], s[16+i], s[i]};
      nib = inv ? INV_SBOX[nib] : SBOX[nib];
      o[i]    = nib[0];
      o[16+i] = nib[1];
      o[32+i] = nib[2];
      o[48+i] = nib[3];
    end
    return o;
  endfunction

  // Row rotations left by 0, 1, 12, 13.
  function automatic rect_state_t shift_row(rect_state_t s);
    return {s[50:48], s[63:51], s[35:32], s[47:36], s[30:16], s[31], s[15:0]};
  endfunction

  // Undo shift_row: rotate left by 0, 15, 4, 3.
  function automatic rect_state_t inv_shift_row(rect_state_t s);
    return {s[60:48], s[63:61], s[43:32], s[47:44], s[16], s[31:17], s[15:0]};
  endfunction

endpackage

// File: rtl/rectangle_rkey_cipher_if.sv
// rectangle_rkey_cipher_if: key-write bus plus plaintext/ciphertext streams.
//   Key bus  : flush, WE, WAddr, KeyIn  ->  keys_ready, key_err
//   Input    : in_valid, pt, dec        <-> in_ready
//   Output   : out_valid, ct            <-> out_ready
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. A source holds valid and its data stable until that edge and
// never waits on ready before raising valid; a sink may change ready freely.
interface rectangle_rkey_cipher_if;
  logic        flush;
  logic        WE;
  logic [4:0]  WAddr;
  logic [63:0] KeyIn;
  logic        keys_ready;
  logic        key_err;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] pt;
  logic        dec;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ct;

  modport master (
    output flush, WE, WAddr, KeyIn, in_valid, pt, dec, out_ready,
    input  keys_ready, key_err, in_ready, out_valid, ct
  );

  modport slave (
    input  flush, WE, WAddr, KeyIn, in_valid, pt, dec, out_ready,
    output keys_ready, key_err, in_ready, out_valid, ct
  );
endinterface

// File: rtl/rectangle_round.sv
// rectangle_round: one combinational RECTANGLE round.
//   state_in  : current state
//   rkey      : round key for this round
//   dec       : 0 = encrypt  ShiftRow(SubColumn(state_in ^ rkey))
//               1 = decrypt  InvSubColumn(InvShiftRow(state_in)) ^ rkey
//   state_out : next state
// The decrypt path exists only when RECT_DECRYPT_EN is defined; otherwise
// dec is ignored.
module rectangle_round
  import rectangle_pkg::*;
(
  input  rect_state_t state_in,
  input  rect_state_t rkey,
  input  logic        dec,
  output rect_state_t state_out
);

  rect_state_t w_enc;
  assign w_enc = shift_row(sub_column(state_in ^ rkey, 1'b0));

`ifdef RECT_DECRYPT_EN
  rect_state_t w_dec;
  assign w_dec     = sub_column(inv_shift_row(state_in), 1'b1) ^ rkey;
  assign state_out = dec ? w_dec : w_enc;
`else
  logic w_unused_dec;
  assign w_unused_dec = dec;
  assign state_out    = w_enc;
`endif

endmodule

// File: rtl/rectangle_rkey_cipher.sv
// rectangle_rkey_cipher: round-key register file plus an iterative
// RECTANGLE block cipher (one round per clock).
//   Clk, RstN   : clock, asynchronous active-low reset
//   bus (slave) : key writes (flush/WE/WAddr/KeyIn -> keys_ready/key_err),
//                 plaintext in (in_valid/in_ready/pt/dec),
//                 ciphertext out (out_valid/out_ready/ct)
//   o_dbg_state : FSM state (rect_fsm_e encoding)
//   o_dbg_rnd   : round counter
//   o_dbg_s     : working state register
// Optional: RECT_DECRYPT_EN adds decryption selected by dec at the input
// handshake.
module rectangle_rkey_cipher
  import rectangle_pkg::*;
(
  input  logic                   Clk,
  input  logic                   RstN,
  rectangle_rkey_cipher_if.slave bus,
  output logic [1:0]             o_dbg_state,
  output logic [4:0]             o_dbg_rnd,
  output rect_state_t            o_dbg_s
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_RUN     = RUN;
  localparam logic [1:0] S_DONE    = DONE;
  localparam logic [4:0] LAST_ADDR = 5'(NUM_RKEYS - 1);
  localparam logic [4:0] LAST_RND  = 5'(NUM_ROUNDS - 1);

  logic [1:0]           r_state;
  logic [4:0]           r_rnd;
  rect_state_t          r_s;
  rect_state_t          r_ct;
  logic                 r_out_valid;
  logic                 r_keys_ready;
  logic                 r_key_err;
  logic [NUM_RKEYS-1:0] r_valid;
  logic [NUM_RKEYS-1:0] w_valid_next;
  rect_state_t          r_keys [NUM_RKEYS];

  logic        w_key_wr;
  logic        w_accept;
  logic        w_dec;
  rect_state_t w_load;
  rect_state_t w_rkey;
  rect_state_t w_round_out;
  rect_state_t w_final;

  // Keys may only change while no block is in flight; flush wins over WE.
  assign w_key_wr = !bus.flush && bus.WE && (r_state == S_IDLE) && (bus.WAddr <= LAST_ADDR);

  assign bus.in_ready = (r_state == S_IDLE) && r_keys_ready;
  assign w_accept     = !bus.flush && bus.in_valid && bus.in_ready;

`ifdef RECT_DECRYPT_EN
  logic r_dec;
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN)         r_dec <= 1'b0;
    else if (w_accept) r_dec <= bus.dec;
  end
  assign w_dec  = r_dec;
  // Decryption starts by removing the final whitening key.
  assign w_load = bus.dec ? (bus.pt ^ r_keys[LAST_ADDR]) : bus.pt;
`else
  logic w_unused_dec;
  assign w_unused_dec = bus.dec;
  assign w_dec        = 1'b0;
  assign w_load       = bus.pt;
`endif

  // Decryption walks the schedule backwards: K[24], K[23], ... K[0].
  assign w_rkey  = w_dec ? r_keys[LAST_RND - r_rnd] : r_keys[r_rnd];
  assign w_final = w_dec ? w_round_out : (w_round_out ^ r_keys[LAST_ADDR]);

  rectangle_round u_round (
    .state_in  (r_s),
    .rkey      (w_rkey),
    .dec       (w_dec),
    .state_out (w_round_out)
  );

  // Key contents need no reset; validity is tracked by r_valid.
  always_ff @(posedge Clk) begin
    if (w_key_wr) r_keys[bus.WAddr] <= bus.KeyIn;
  end

  always_comb begin
    w_valid_next = r_valid;
    if (bus.flush)     w_valid_next = '0;
    else if (w_key_wr) w_valid_next[bus.WAddr] = 1'b1;
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_valid      <= '0;
      r_keys_ready <= 1'b0;
      r_key_err    <= 1'b0;
    end else begin
      r_valid      <= w_valid_next;
      r_keys_ready <= &w_valid_next;
      if (bus.flush)                         r_key_err <= 1'b0;
      else if (bus.WE && r_state != S_IDLE)  r_key_err <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state     <= S_IDLE;
      r_rnd       <= '0;
      r_s         <= '0;
      r_ct        <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= S_IDLE;
      r_rnd       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_s     <= w_load;
            r_rnd   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_s <= w_round_out;
          if (r_rnd == LAST_RND) begin
            r_ct        <= w_final;
            r_out_valid <= 1'b1;
            r_rnd       <= '0;
            r_state     <= S_DONE;
          end else begin
            r_rnd <= r_rnd + 5'd1;
          end
        end
        S_DONE: begin
          // No new input is taken in the same cycle the result leaves.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.keys_ready = r_keys_ready;
  assign bus.key_err    = r_key_err;
  assign bus.out_valid  = r_out_valid;
  assign bus.ct         = r_ct;

  assign o_dbg_state = r_state;
  assign o_dbg_rnd   = r_rnd;
  assign o_dbg_s     = r_s;

endmodule

// File: tb/tb_rectangle_rkey_cipher.sv
// tb_rectangle_rkey_cipher: self-checking bench for rectangle_rkey_cipher.
// Reference model works on rows/columns as integers; expected ciphertexts
// go through exp_q and are compared when the DUT presents its output.
module tb_rectangle_rkey_cipher;
  import rectangle_pkg::*;

  // clock / reset
  logic Clk  = 1'b0;
  logic RstN = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  rectangle_rkey_cipher_if bus ();
  logic [1:0]  dbg_state;
  logic [4:0]  dbg_rnd;
  logic [63:0] dbg_s;

  rectangle_rkey_cipher dut (
    .Clk         (Clk),
    .RstN        (RstN),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_rnd   (dbg_rnd),
    .o_dbg_s     (dbg_s)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] m_keys[26];
  int unsigned hs_cyc = 0;

  int m_sbox[16]  = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};
  int m_isbox[16] = '{9, 4, 15, 10, 14, 1, 0, 6, 12, 7, 3, 8, 2, 11, 5, 13};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // reference model
  function automatic logic [63:0] m_subcol(input logic [63:0] s, input bit inv);
    int rows[4];
    int outr[4];
    int v;
    for (int j = 0; j < 4; j++) begin
      rows[j] = int'(s[16*j +: 16]);
      outr[j] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      v = 0;
      for (int j = 0; j < 4; j++) v = v | (((rows[j] >> i) & 1) << j);
      v = inv ? m_isbox[v] : m_sbox[v];
      for (int j = 0; j < 4; j++) outr[j] = outr[j] | (((v >> j) & 1) << i);
    end
    return {16'(outr[3]), 16'(outr[2]), 16'(outr[1]), 16'(outr[0])};
  endfunction

  function automatic logic [63:0] m_shift(input logic [63:0] s, input bit inv);
    logic [63:0] o;
    int r;
    int n;
    o = '0;
    for (int j = 0; j < 4; j++) begin
      r = int'(s[16*j +: 16]);
      n = (j == 0) ? 0 : (j == 1) ? 1 : (j == 2) ? 12 : 13;
      if (inv) n = (16 - n) % 16;
      r = ((r << n) | (r >> (16 - n))) & 'hFFFF;
      o[16*j +: 16] = 16'(r);
    end
    return o;
  endfunction

  function automatic logic [63:0] m_encrypt(input logic [63:0] p);
    logic [63:0] s;
    s = p;
    for (int r = 0; r < 25; r++) s = m_shift(m_subcol(s ^ m_keys[r], 1'b0), 1'b0);
    return s ^ m_keys[25];
  endfunction

  function automatic logic [63:0] m_decrypt(input logic [63:0] c);
    logic [63:0] s;
    s = c ^ m_keys[25];
    for (int r = 24; r >= 0; r--) s = m_subcol(m_shift(s, 1'b1), 1'b1) ^ m_keys[r];
    return s;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_key(input int addr, input logic [63:0] data);
    bus.WE    = 1'b1;
    bus.WAddr = 5'(addr);
    bus.KeyIn = data;
    tick();
    bus.WE = 1'b0;
    if (addr < 26) m_keys[addr] = data;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  // kind 0: all zero, 1: derived from seed, 2: random
  task automatic load_keys(input int kind, input logic [63:0] seed);
    logic [63:0] k;
    k = seed;
    for (int a = 0; a < 26; a++) begin
      if (kind == 0)      k = 64'd0;
      else if (kind == 1) k = {k[50:0], k[63:51]} ^ (64'(a) * 64'h9E3779B97F4A7C15);
      else                k = {$urandom, $urandom};
      if (a == 25) check("kr_before_last", 64'(bus.keys_ready), 64'd0);
      write_key(a, k);
    end
    check("kr_after_last", 64'(bus.keys_ready), 64'd1);
  endtask

  task automatic start_block(input logic [63:0] p, input logic d);
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.pt       = p;
    bus.dec      = d;
    tick();
    bus.in_valid = 1'b0;
    bus.dec      = 1'b0;
    hs_cyc       = cyc;
    exp_q.push_back(d ? m_decrypt(p) : m_encrypt(p));
  endtask

  task automatic finish_block(input int hold);
    int budget;
    logic [63:0] exp;
    budget = 0;
    while (!bus.out_valid && budget < 60) begin
      tick();
      budget++;
    end
    check("latency", 64'(cyc - hs_cyc), 64'd25);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
    check("ct", bus.ct, exp);
    if (hold > 0) begin
      repeat (hold) tick();
      check("ct_hold", bus.ct, exp);
      check("valid_hold", 64'(bus.out_valid), 64'd1);
      check("in_ready_done", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_clr", 64'(bus.out_valid), 64'd0);
    check("in_ready_back", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ct_zero;
    bit seen;
    bus.flush = 1'b0; bus.WE = 1'b0; bus.WAddr = '0; bus.KeyIn = '0;
    bus.in_valid = 1'b1; bus.pt = '0; bus.dec = 1'b0; bus.out_ready = 1'b0;

    // reset
    RstN = 1'b0;
    repeat (2) tick();
    check("rst_keys_ready", 64'(bus.keys_ready), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_key_err", 64'(bus.key_err), 64'd0);
    check("rst_ct", bus.ct, 64'd0);
    RstN = 1'b1;
    tick();
    check("no_accept_state", 64'(dbg_state), 64'(IDLE));
    check("no_accept_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;

    // key store: full load, then a load missing entry 13 plus an out-of-range write
    load_keys(0, 64'd0);
    do_flush();
    check("flush_kr", 64'(bus.keys_ready), 64'd0);
    for (int a = 0; a < 26; a++) if (a != 13) write_key(a, 64'd0);
    check("kr_missing13", 64'(bus.keys_ready), 64'd0);
    write_key(30, 64'hDEADBEEFCAFEF00D);
    check("kr_addr30", 64'(bus.keys_ready), 64'd0);
    check("key_err_addr30", 64'(bus.key_err), 64'd0);
    write_key(13, 64'd0);
    check("kr_full", 64'(bus.keys_ready), 64'd1);

    // zero keys, zero plaintext, output held off for 10 cycles
    start_block(64'd0, 1'b0);
    tick();
    check("first_round", dbg_s, 64'h0000FFFFFFFF0000);
    finish_block(10);
    ct_zero = m_encrypt(64'd0);
`ifdef RECT_DECRYPT_EN
    start_block(ct_zero, 1'b1);
    finish_block(0);
`endif

    // derived schedule from 64'hAABB09182736CCDD
    do_flush();
    load_keys(1, 64'hAABB09182736CCDD);
    for (int i = 0; i < 3; i++) begin
      start_block({$urandom, $urandom}, 1'b0);
      finish_block(i);
    end

    // flush in the middle of a block
    start_block({$urandom, $urandom}, 1'b0);
    repeat (10) tick();
    check("rnd10", 64'(dbg_rnd), 64'd10);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    exp_q.delete();
    check("flush_state", 64'(dbg_state), 64'(IDLE));
    check("flush_kr_mid", 64'(bus.keys_ready), 64'd0);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check("no_out_after_flush", 64'(seen), 64'd0);
    check("no_ready_after_flush", 64'(bus.in_ready), 64'd0);

    // fresh random keys
    load_keys(2, 64'd0);
    start_block({$urandom, $urandom}, 1'b0);
    finish_block(0);
`ifdef RECT_DECRYPT_EN
    start_block({$urandom, $urandom}, 1'b1);
    finish_block(0);
`endif

    // key write while busy
    start_block({$urandom, $urandom}, 1'b0);
    repeat (3) tick();
    bus.WE    = 1'b1;
    bus.WAddr = 5'd5;
    bus.KeyIn = ~m_keys[5];
    tick();
    bus.WE = 1'b0;
    check("key_err_set", 64'(bus.key_err), 64'd1);
    finish_block(0);
    check("key_err_sticky", 64'(bus.key_err), 64'd1);
    start_block({$urandom, $urandom}, 1'b0);
    finish_block(0);
    do_flush();
    check("key_err_clr", 64'(bus.key_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
